rx_mac: RTL and testbench
=========================

# rx_mac

Ethernet MAC receive datapath, the receive-side counterpart of `tx_mac`. It takes the byte stream delivered by the RGMII receive interface and recognises the preamble and SFD. It strips the 4-byte FCS, checks CRC-32 and frame length, and presents the payload as an AXI-Stream master into the RX FIFO. Frames are never stalled, so the block has no ready input. Every byte is forwarded as it arrives, and bad frames are flagged on `m_rx_axis_tuser` at `m_rx_axis_tlast`.

## Interface
- `DATA_WIDTH`, default 8: byte lane width. Only 8 is supported.
- `MIN_FRAME`, default 64: minimum legal frame length in bytes, counted after the SFD and including the FCS.
- `MAX_FRAME`, default 1518: maximum legal frame length in bytes, counted the same way.

- `clk`  in  1: single clock, 125 MHz. Everything is synchronous to its rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `rgmii_mac_rx_data`  in  8: received byte, qualified by `rgmii_mac_rx_dv`.
- `rgmii_mac_rx_dv`  in  1: receive data valid. It is contiguous for the whole frame.
- `rgmii_mac_rx_er`  in  1: PHY receive error, sampled while `rgmii_mac_rx_dv`=1.
- `m_rx_axis_tdata`  out  8: payload byte.
- `m_rx_axis_tvalid`  out  1: one-cycle pulse per payload byte.
- `m_rx_axis_tlast`  out  1: marks the last payload byte of the frame.
- `m_rx_axis_tuser`  out  1: bad frame. Meaningful only on the `tlast` beat; 0 on every other beat.

## Operation
- State machine states: IDLE, PREAMBLE, PAYLOAD, DROP.
- **IDLE**
  - `dv`=1 with data 0x55 → PREAMBLE.
  - `dv`=1 with any other byte → DROP.
- **PREAMBLE**
  - 0x55 → stay in PREAMBLE.
  - 0xD5 → PAYLOAD. The CRC register is initialised to 0xFFFFFFFF and the byte counter is cleared.
  - Any other byte, or `dv`=0 → DROP (or IDLE if `dv`=0).
- **PAYLOAD**
  - Every sampled byte increments the 11-bit byte counter, which saturates at 2047.
  - Every sampled byte updates the CRC. The CRC is reflected CRC-32 (polynomial 0x04C11DB7), processed LSB first.
  - `rgmii_mac_rx_er`=1 latches a sticky error flag.
  - The first cycle with `dv`=0 → IDLE.
- **DROP**: wait for `dv`=0, then → IDLE. Nothing is emitted.
- **FCS strip**
  - A 4-byte delay line holds FCS candidates.
  - Behind it sits a one-byte pending register.
  - When a byte is sampled while the delay line is full, the oldest delay-line byte moves into pending. If pending already held a byte, that byte is emitted with `tlast`=0.
  - On the first `dv`=0 in PAYLOAD:
    - If pending is valid, it is emitted with `tlast`=1 and `tuser`=bad.
    - If pending is not valid (fewer than 5 bytes after the SFD), nothing is emitted and the frame is discarded.
- **Bad frame**: `tuser`=1 if any of the following holds.
  - The error flag is set.
  - The byte count is less than `MIN_FRAME`.
  - The byte count is greater than `MAX_FRAME`.
  - The CRC register after the FCS is not equal to the residue 0xDEBB20E3.
- **Reset mid-frame**: all state is cleared. A frame in progress is truncated with no `tlast` beat. If `dv` is still high when reset is released, the remainder of that frame goes through DROP.

## Timing
- Reset values: `m_rx_axis_tdata`=0x00, `tvalid`=0, `tlast`=0, `tuser`=0, state=IDLE, delay line and pending empty.
- All outputs are registered. `tdata`, `tlast` and `tuser` hold their value when `tvalid`=0.
- Latency:
  - Payload byte Dn is valid in the cycle after the edge that samples Dn+5.
  - The final byte is valid in the cycle after the edge that samples the first `dv`=0.
- Beats within a frame are back-to-back, with no gaps.
- Frames may be separated by a single `dv`=0 cycle. The final beat of frame N and the preamble of frame N+1 never conflict.
- `rgmii_mac_rx_er` on the same edge that `dv` falls is ignored.

## Configuration
- Macro: `RX_MAC_CRC_CHECK_EN`.
- Defined: the CRC is computed, and a residue mismatch sets `tuser`.
- Undefined: no CRC logic is built. The FCS is still stripped, and `tuser` is driven only by the error flag and the length checks.

## Test plan
- **Good frame**: 7×0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS → 60 beats 0x00..0x3B; `tlast` on 0x3B; `tuser`=0; first `tvalid` in the cycle after D5 is sampled.
- **Corrupted payload**: same frame with byte 10 XOR 0x01 → 60 beats; `tuser`=1 on `tlast`. With `RX_MAC_CRC_CHECK_EN` undefined → `tuser`=0.
- **PHY error**: `rgmii_mac_rx_er`=1 for one cycle on payload byte 20 of the good frame → `tuser`=1 on `tlast`, all 60 bytes still delivered.
- **Runt**: 36 payload bytes plus a valid FCS (40 bytes) → 36 beats, `tuser`=1. A 3-byte frame after the SFD → no beats at all.
- **Bad preamble**: third preamble byte 0x5A → no output. A good frame after one idle cycle → delivered correctly, `tuser`=0.
- **Reset mid-frame**: `reset_n`=0 for 2 cycles at payload byte 30 → `tvalid`=0 from the next cycle, no `tlast` for that frame. The following good frame → delivered correctly.

Source files
------------

// File: rtl/rx_mac.sv
// rx_mac: Ethernet receive MAC. Detects preamble/SFD, strips the FCS, and flags bad frames on tuser at tlast.
// Optional macro RX_MAC_CRC_CHECK_EN builds the CRC-32 residue check into the bad-frame decision.
module rx_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_FRAME  = 64,
  parameter int MAX_FRAME  = 1518
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rgmii_mac_rx_data,
  input  logic                  rgmii_mac_rx_dv,
  input  logic                  rgmii_mac_rx_er,
  output logic [DATA_WIDTH-1:0] m_rx_axis_tdata,
  output logic                  m_rx_axis_tvalid,
  output logic                  m_rx_axis_tlast,
  output logic                  m_rx_axis_tuser
);

  localparam logic [DATA_WIDTH-1:0] PRE_BYTE = 8'h55;
  localparam logic [DATA_WIDTH-1:0] SFD_BYTE = 8'hD5;
  localparam logic [10:0]           MIN_LEN  = 11'(MIN_FRAME);
  localparam logic [10:0]           MAX_LEN  = 11'(MAX_FRAME);

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

  state_t                state, next_state;
  logic                  start_frame, accept, end_frame;
  logic [DATA_WIDTH-1:0] dline [4];
  logic [2:0]            dline_cnt;
  logic [DATA_WIDTH-1:0] pend;
  logic                  pend_vld;
  logic [10:0]           byte_cnt;
  logic                  err_flag;
  logic                  crc_bad;
  logic                  frame_bad;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    accept      = 1'b0;
    end_frame   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rgmii_mac_rx_dv)
          next_state = (rgmii_mac_rx_data == PRE_BYTE) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!rgmii_mac_rx_dv) begin
          next_state = IDLE;
        end else if (rgmii_mac_rx_data == SFD_BYTE) begin
          next_state  = PAYLOAD;
          start_frame = 1'b1;
        end else if (rgmii_mac_rx_data != PRE_BYTE) begin
          next_state = DROP;
        end
      end
      PAYLOAD: begin
        if (rgmii_mac_rx_dv) begin
          accept = 1'b1;
        end else begin
          end_frame  = 1'b1;
          next_state = IDLE;
        end
      end
      DROP: begin
        if (!rgmii_mac_rx_dv) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef RX_MAC_CRC_CHECK_EN
  logic [31:0] crc;

  // Reflected CRC-32: shift right, XOR with the bit-reversed polynomial 0xEDB88320.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] d);
    logic [31:0] c;
    c = crc_in ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n)         crc <= '1;
    else if (start_frame) crc <= '1;
    else if (accept)      crc <= crc32_byte(crc, rgmii_mac_rx_data);
  end

  assign crc_bad = (crc != 32'hDEBB20E3);
`else
  assign crc_bad = 1'b0;
`endif

  assign frame_bad = err_flag || (byte_cnt < MIN_LEN) || (byte_cnt > MAX_LEN) || crc_bad;

  // The newest byte enters dline[3]; once four are held, dline[0] is the oldest and feeds pend.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dline            <= '{default: '0};
      dline_cnt        <= 3'd0;
      pend             <= '0;
      pend_vld         <= 1'b0;
      byte_cnt         <= 11'd0;
      err_flag         <= 1'b0;
      m_rx_axis_tdata  <= '0;
      m_rx_axis_tvalid <= 1'b0;
      m_rx_axis_tlast  <= 1'b0;
      m_rx_axis_tuser  <= 1'b0;
    end else begin
      m_rx_axis_tvalid <= 1'b0;
      if (start_frame) begin
        dline_cnt <= 3'd0;
        pend_vld  <= 1'b0;
        byte_cnt  <= 11'd0;
        err_flag  <= 1'b0;
      end else if (accept) begin
        dline[0] <= dline[1];
        dline[1] <= dline[2];
        dline[2] <= dline[3];
        dline[3] <= rgmii_mac_rx_data;
        if (byte_cnt != '1) byte_cnt <= byte_cnt + 11'd1;
        if (rgmii_mac_rx_er) err_flag <= 1'b1;
        if (dline_cnt == 3'd4) begin
          pend     <= dline[0];
          pend_vld <= 1'b1;
          if (pend_vld) begin
            m_rx_axis_tdata  <= pend;
            m_rx_axis_tvalid <= 1'b1;
            m_rx_axis_tlast  <= 1'b0;
            m_rx_axis_tuser  <= 1'b0;
          end
        end else begin
          dline_cnt <= dline_cnt + 3'd1;
        end
      end else if (end_frame) begin
        if (pend_vld) begin
          m_rx_axis_tdata  <= pend;
          m_rx_axis_tvalid <= 1'b1;
          m_rx_axis_tlast  <= 1'b1;
          m_rx_axis_tuser  <= frame_bad;
        end
        pend_vld  <= 1'b0;
        dline_cnt <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_rx_mac.sv
// tb_rx_mac: directed and random frames for rx_mac, checked against a frame-level reference model
// (expected beats derived from preamble validity, frame length, PHY errors and a table-driven FCS).
module tb_rx_mac;

  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1518;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic       rx_er;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  int numChecks = 0;
  int numFails  = 0;

  logic [31:0] crcTable [256];
  logic [7:0]  preQ[$];
  logic [7:0]  bodyQ[$];

  int randLen;
  int randIdx;
  int randEr;

  rx_mac #(.DATA_WIDTH(8), .MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .rgmii_mac_rx_data(rx_data),
    .rgmii_mac_rx_dv  (rx_dv),
    .rgmii_mac_rx_er  (rx_er),
    .m_rx_axis_tdata  (tdata),
    .m_rx_axis_tvalid (tvalid),
    .m_rx_axis_tlast  (tlast),
    .m_rx_axis_tuser  (tuser)
  );

  always #4 clk = ~clk;

  function automatic void buildTable();
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crcTable[n] = c;
    end
  endfunction

  // Ethernet FCS value (complemented CRC) over the first len bytes of the body.
  function automatic logic [31:0] fcsOf(input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) c = (c >> 8) ^ crcTable[c[7:0] ^ bodyQ[i]];
    return ~c;
  endfunction

  function automatic void setPreamble(input int n55);
    preQ = {};
    for (int i = 0; i < n55; i++) preQ.push_back(8'h55);
    preQ.push_back(8'hD5);
  endfunction

  // kind 0: incrementing payload, kind 1: random payload; the correct FCS is appended LSB first.
  function automatic void makeFrame(input int len, input int kind);
    logic [31:0] fcs;
    bodyQ = {};
    for (int i = 0; i < len; i++) bodyQ.push_back(kind == 0 ? 8'(i) : 8'($urandom));
    fcs = fcsOf(len);
    bodyQ.push_back(fcs[7:0]);
    bodyQ.push_back(fcs[15:8]);
    bodyQ.push_back(fcs[23:16]);
    bodyQ.push_back(fcs[31:24]);
  endfunction

  function automatic bit preambleOk();
    if (preQ.size() < 2) return 1'b0;
    if (preQ[preQ.size()-1] != 8'hD5) return 1'b0;
    for (int i = 0; i < preQ.size() - 1; i++)
      if (preQ[i] != 8'h55) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit modelBad(input int erIdx);
    int n;
    bit bad;
    logic [31:0] fcs;
    n = bodyQ.size();
    bad = 1'b0;
    if (erIdx >= 0 && erIdx < n) bad = 1'b1;
    if (n < MIN_FRAME || n > MAX_FRAME) bad = 1'b1;
`ifdef RX_MAC_CRC_CHECK_EN
    fcs = {bodyQ[n-1], bodyQ[n-2], bodyQ[n-3], bodyQ[n-4]};
    if (fcsOf(n - 4) != fcs) bad = 1'b1;
`else
    fcs = 32'd0;
`endif
    return bad;
  endfunction

  task automatic checkOutput(input string tag, input bit expValid, input logic [7:0] expData,
                             input bit expLast, input bit expUser);
    numChecks++;
    assert (tvalid === expValid) else begin
      numFails++;
      $error("[TB] FAIL %s tvalid: observed %b expected %b", tag, tvalid, expValid);
    end
    if (expValid) begin
      numChecks++;
      assert (tdata === expData) else begin
        numFails++;
        $error("[TB] FAIL %s tdata: observed %h expected %h", tag, tdata, expData);
      end
      numChecks++;
      assert ({tlast, tuser} === {expLast, expUser}) else begin
        numFails++;
        $error("[TB] FAIL %s tlast/tuser: observed %b%b expected %b%b", tag, tlast, tuser, expLast, expUser);
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    numChecks++;
    assert ({tdata, tvalid, tlast, tuser} === 11'd0) else begin
      numFails++;
      $error("[TB] FAIL %s reset values: observed %h/%b%b%b expected 00/000", tag, tdata, tvalid, tlast, tuser);
    end
  endtask

  // Drives preQ then bodyQ, then one dv=0 cycle plus gap idle cycles, checking every cycle.
  task automatic applyStimulus(input string tag, input int erIdx, input int resetAt,
                               input bit erAtEnd, input int gap);
    bit ok;
    bit dead;
    int n;
    ok   = preambleOk();
    dead = 1'b0;
    n    = bodyQ.size();
    for (int i = 0; i < preQ.size(); i++) begin
      rx_dv = 1'b1; rx_er = 1'b0; rx_data = preQ[i];
      @(posedge clk); #1;
      checkOutput({tag, "/pre"}, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    for (int j = 0; j < n; j++) begin
      rx_dv   = 1'b1;
      rx_data = bodyQ[j];
      rx_er   = (j == erIdx);
      reset_n = !(resetAt >= 0 && (j == resetAt || j == resetAt + 1));
      @(posedge clk); #1;
      if (!reset_n) begin
        dead = 1'b1;
        checkResetValues({tag, "/rst"});
      end else if (ok && !dead && j >= 5) begin
        checkOutput($sformatf("%s/b%0d", tag, j - 5), 1'b1, bodyQ[j-5], 1'b0, 1'b0);
      end else begin
        checkOutput($sformatf("%s/c%0d", tag, j), 1'b0, 8'h00, 1'b0, 1'b0);
      end
    end
    reset_n = 1'b1;
    rx_dv   = 1'b0;
    rx_er   = erAtEnd;
    rx_data = 8'h00;
    @(posedge clk); #1;
    rx_er = 1'b0;
    if (ok && !dead && n >= 5)
      checkOutput({tag, "/last"}, 1'b1, bodyQ[n-5], 1'b1, modelBad(erIdx));
    else
      checkOutput({tag, "/end"}, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      checkOutput({tag, "/gap"}, 1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  initial begin
    buildTable();
    reset_n = 1'b0;
    rx_dv   = 1'b0;
    rx_er   = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] good frame");
    setPreamble(7); makeFrame(60, 0);
    applyStimulus("good", -1, -1, 1'b0, 0);

    $display("[TB] corrupted payload byte 10");
    setPreamble(7); makeFrame(60, 0);
    bodyQ[10] = bodyQ[10] ^ 8'h01;
    applyStimulus("corrupt", -1, -1, 1'b0, 0);

    $display("[TB] PHY error on byte 20");
    setPreamble(7); makeFrame(60, 0);
    applyStimulus("phyerr", 20, -1, 1'b0, 0);

    $display("[TB] rx_er on the dv falling edge");
    setPreamble(7); makeFrame(60, 0);
    applyStimulus("erfall", -1, -1, 1'b1, 1);

    $display("[TB] runts");
    setPreamble(7); makeFrame(36, 0);
    applyStimulus("runt40", -1, -1, 1'b0, 0);
    setPreamble(7);
    bodyQ = {};
    for (int i = 0; i < 3; i++) bodyQ.push_back(8'($urandom));
    applyStimulus("runt3", -1, -1, 1'b0, 0);
    setPreamble(3); makeFrame(0, 1);
    applyStimulus("runt4", -1, -1, 1'b0, 0);
    setPreamble(3); makeFrame(1, 1);
    applyStimulus("runt5", -1, -1, 1'b0, 0);

    $display("[TB] length boundaries");
    setPreamble(7); makeFrame(59, 1);
    applyStimulus("len63", -1, -1, 1'b0, 0);
    setPreamble(7); makeFrame(60, 1);
    applyStimulus("len64", -1, -1, 1'b0, 0);
    setPreamble(7); makeFrame(1514, 1);
    applyStimulus("len1518", -1, -1, 1'b0, 0);
    setPreamble(7); makeFrame(1515, 1);
    applyStimulus("len1519", -1, -1, 1'b0, 0);

    $display("[TB] bad preamble then good frame");
    preQ = {8'h55, 8'h55, 8'h5A, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
    makeFrame(60, 0);
    applyStimulus("badpre", -1, -1, 1'b0, 0);
    setPreamble(7); makeFrame(60, 0);
    applyStimulus("afterbad", -1, -1, 1'b0, 0);

    $display("[TB] reset mid-frame then good frame");
    setPreamble(7); makeFrame(60, 0);
    applyStimulus("midrst", -1, 30, 1'b0, 0);
    setPreamble(7); makeFrame(60, 0);
    applyStimulus("afterrst", -1, -1, 1'b0, 0);

    $display("[TB] random frames");
    for (int f = 0; f < 16; f++) begin
      randLen = $urandom_range(0, 100);
      setPreamble($urandom_range(1, 7));
      makeFrame(randLen, 1);
      if ($urandom_range(0, 3) == 0) begin
        randIdx = $urandom_range(0, bodyQ.size() - 1);
        bodyQ[randIdx] = bodyQ[randIdx] ^ (8'h01 << $urandom_range(0, 7));
      end
      randEr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, bodyQ.size() - 1)) : -1;
      applyStimulus($sformatf("rand%0d", f), randEr, -1, 1'b0, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
